// File: rtl/quad_pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : quad_pe_pkg
// Purpose  : Shared types, lane geometry and unpack helper for the quad-lane
//            PE operand feeder.
// Revision : 1.0 - initial release
// ============================================================================
package quad_pe_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic [LANES-1:0][LANE_W-1:0] ifm;
    logic [LANES-1:0][LANE_W-1:0] weight;
    logic [LANES-1:0][LANE_W-1:0] coef;
    logic                         pe_reset;
    logic                         pe_finish;
  } pe_operands_t;

  // Lane k (1-based) is bits [8k-1:8k-8] of the SRAM word.
  function automatic logic [LANE_W-1:0] unpack_lane(input logic [WORD_W-1:0] word,
                                                     input int k);
    return LANE_W'(word >> (LANE_W * (k - 1)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_pe_feeder.sv
`default_nettype none
// ============================================================================
// Module   : quad_pe_feeder
// Purpose  : Issues one IFM/weight/coef SRAM read per channel group and
//            presents the unpacked byte lanes to the PE two cycles later,
//            tagging the first and last group; bubbles carry zero operands.
// Revision : 1.0 - initial release
// ============================================================================
module quad_pe_feeder
  import quad_pe_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_num_groups,
  input  logic [ADDR_W-1:0] cfg_ifm_base,
  input  logic [ADDR_W-1:0] cfg_wgt_base,
  input  logic              cfg_mul_en,
  input  logic              mem_stall,
  output logic              ifm_rd_en,
  output logic [ADDR_W-1:0] ifm_rd_addr,
  input  logic [31:0]       ifm_rd_data,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  input  logic [31:0]       wgt_rd_data,
  input  logic [31:0]       coef_rd_data,
  output logic [7:0]        ifm1,
  output logic [7:0]        ifm2,
  output logic [7:0]        ifm3,
  output logic [7:0]        ifm4,
  output logic [7:0]        weight1,
  output logic [7:0]        weight2,
  output logic [7:0]        weight3,
  output logic [7:0]        weight4,
  output logic [7:0]        coef1,
  output logic [7:0]        coef2,
  output logic [7:0]        coef3,
  output logic [7:0]        coef4,
  output logic              mul_en,
  output logic              pe_reset,
  output logic              pe_finish,
  output logic              busy,
  output logic              done
);

  feeder_state_t     r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt, r_num_groups;
  logic [ADDR_W-1:0] r_ifm_base, r_wgt_base;
  logic              r_mul_en, r_done;
  logic              w_issue, w_last_issue, w_accept, w_zero_job, w_drain_done;
  logic              r_s1_valid, r_s1_first, r_s1_last;
  pe_operands_t      r_out, w_out_next;

  // Next-state decode; a read is issued in every unstalled ISSUE cycle.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_last_issue = 1'b0;
    w_accept     = 1'b0;
    w_zero_job   = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_num_groups != '0) begin
            w_accept     = 1'b1;
            w_next_state = ST_ISSUE;
          end else begin
            w_zero_job = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (!mem_stall) begin
          w_issue = 1'b1;
          if (r_cnt == r_num_groups - CNT_W'(1)) begin
            w_last_issue = 1'b1;
            w_next_state = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Last group is on the PE ports this cycle; the job ends at this edge.
        if (r_out.pe_finish) begin
          w_drain_done = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Job configuration latch and group counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_num_groups <= '0;
      r_ifm_base   <= '0;
      r_wgt_base   <= '0;
      r_mul_en     <= 1'b0;
    end else if (w_accept) begin
      r_cnt        <= '0;
      r_num_groups <= cfg_num_groups;
      r_ifm_base   <= cfg_ifm_base;
      r_wgt_base   <= cfg_wgt_base;
      r_mul_en     <= cfg_mul_en;
    end else if (w_issue) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Done pulse: either an empty job or the last group leaving the output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_done <= 1'b0;
    else          r_done <= w_zero_job | w_drain_done;
  end

  // Stage-1 tags travel alongside the SRAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_first <= w_issue && (r_cnt == '0);
      r_s1_last  <= w_last_issue;
    end
  end

  // Unpack returned words into lanes; bubbles become all-zero operands.
  always_comb begin
    w_out_next = '0;
    if (r_s1_valid) begin
      for (int k = 1; k <= LANES; k++) begin
        w_out_next.ifm[k-1]    = unpack_lane(ifm_rd_data, k);
        w_out_next.weight[k-1] = unpack_lane(wgt_rd_data, k);
        w_out_next.coef[k-1]   = unpack_lane(coef_rd_data, k);
      end
      w_out_next.pe_reset  = r_s1_first;
      w_out_next.pe_finish = r_s1_last;
    end
  end

  // Stage-2 output register driving the PE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_out <= '0;
    else          r_out <= w_out_next;
  end

  assign ifm_rd_en   = w_issue;
  assign wgt_rd_en   = w_issue;
  assign ifm_rd_addr = r_ifm_base + ADDR_W'(r_cnt);
  assign wgt_rd_addr = r_wgt_base + ADDR_W'(r_cnt);

  assign ifm1    = r_out.ifm[0];
  assign ifm2    = r_out.ifm[1];
  assign ifm3    = r_out.ifm[2];
  assign ifm4    = r_out.ifm[3];
  assign weight1 = r_out.weight[0];
  assign weight2 = r_out.weight[1];
  assign weight3 = r_out.weight[2];
  assign weight4 = r_out.weight[3];
  assign coef1   = r_out.coef[0];
  assign coef2   = r_out.coef[1];
  assign coef3   = r_out.coef[2];
  assign coef4   = r_out.coef[3];

  assign pe_reset  = r_out.pe_reset;
  assign pe_finish = r_out.pe_finish;
  assign mul_en    = r_mul_en;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_quad_pe_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_pe_feeder
// Purpose  : Self-checking bench for quad_pe_feeder with SRAM models and a
//            cycle-schedule reference built from the job timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_pe_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start = 1'b0;
  logic [9:0]  cfg_num_groups = '0;
  logic [9:0]  cfg_ifm_base = '0;
  logic [9:0]  cfg_wgt_base = '0;
  logic        cfg_mul_en = 1'b0;
  logic        mem_stall = 1'b0;
  logic        ifm_rd_en, wgt_rd_en;
  logic [9:0]  ifm_rd_addr, wgt_rd_addr;
  logic [31:0] ifm_rd_data = '0, wgt_rd_data = '0, coef_rd_data = '0;
  logic [7:0]  ifm1, ifm2, ifm3, ifm4;
  logic [7:0]  weight1, weight2, weight3, weight4;
  logic [7:0]  coef1, coef2, coef3, coef4;
  logic        mul_en, pe_reset, pe_finish, busy, done;
  logic [95:0] lanes;

  quad_pe_feeder #(.ADDR_W(10), .CNT_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_num_groups(cfg_num_groups), .cfg_ifm_base(cfg_ifm_base),
    .cfg_wgt_base(cfg_wgt_base), .cfg_mul_en(cfg_mul_en), .mem_stall(mem_stall),
    .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr), .ifm_rd_data(ifm_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .coef_rd_data(coef_rd_data),
    .ifm1(ifm1), .ifm2(ifm2), .ifm3(ifm3), .ifm4(ifm4),
    .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4),
    .coef1(coef1), .coef2(coef2), .coef3(coef3), .coef4(coef4),
    .mul_en(mul_en), .pe_reset(pe_reset), .pe_finish(pe_finish),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign lanes = {coef4, coef3, coef2, coef1, weight4, weight3, weight2, weight1,
                  ifm4, ifm3, ifm2, ifm1};

  // SRAM models with one-cycle read latency.
  logic [31:0] ifm_mem [1024];
  logic [31:0] wgt_mem [1024];
  logic [31:0] coef_mem [1024];

  always @(posedge clk) begin
    if (ifm_rd_en) ifm_rd_data <= ifm_mem[ifm_rd_addr];
    if (wgt_rd_en) begin
      wgt_rd_data  <= wgt_mem[wgt_rd_addr];
      coef_rd_data <= coef_mem[wgt_rd_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_mul  = 1'b0;

  // Expected per-cycle behaviour of the current job, indexed by cycle number.
  bit          e_rd   [512];
  bit          e_ad   [512];
  logic [9:0]  e_ai   [512];
  logic [9:0]  e_aw   [512];
  logic [95:0] e_lane [512];
  bit          e_rst  [512];
  bit          e_fin  [512];
  bit          e_busy [512];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_zero();
    check_eq("rst_ctrl", {ifm_rd_en, wgt_rd_en, ifm_rd_addr, wgt_rd_addr,
                          busy, done, pe_reset, pe_finish, mul_en}, '0);
    check_eq("rst_lanes", lanes, '0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      start     = 1'b0;
      mem_stall = 1'($urandom);
      #1;
      check_eq("idle_ctrl", {ifm_rd_en, wgt_rd_en, busy, done, pe_reset, pe_finish}, '0);
      check_eq("idle_lanes", lanes, '0);
      check_eq("idle_mul_en", mul_en, exp_mul);
    end
  endtask

  // Drives start in the current cycle (cycle 0) and checks cycles 1..done.
  task automatic run_job(input int n, input logic [9:0] ib, input logic [9:0] wb,
                         input bit mul, input int pct, input logic [31:0] mask,
                         input bit busy_start, input int abort_at);
    int g, last, done_c;
    bit stl [512];
    for (int c = 0; c < 512; c++) begin
      stl[c] = (c < 32) ? mask[c[4:0]] : 1'b0;
      if (c > 0 && c < 400 && pct > 0 && int'($urandom_range(99, 0)) < pct) stl[c] = 1'b1;
      e_rd[c] = 0; e_ad[c] = 0; e_ai[c] = '0; e_aw[c] = '0;
      e_lane[c] = '0; e_rst[c] = 0; e_fin[c] = 0; e_busy[c] = 0;
    end
    g = 0;
    last = 0;
    for (int c = 1; g < n; c++) begin
      e_ad[c] = 1'b1;
      e_ai[c] = ib + 10'(g);
      e_aw[c] = wb + 10'(g);
      if (!stl[c]) begin
        e_rd[c]     = 1'b1;
        e_lane[c+2] = {coef_mem[e_aw[c]], wgt_mem[e_aw[c]], ifm_mem[e_ai[c]]};
        e_rst[c+2]  = (g == 0);
        e_fin[c+2]  = (g == n - 1);
        last = c;
        g++;
      end
    end
    done_c = (n == 0) ? 1 : last + 3;
    for (int c = 1; c < done_c; c++) e_busy[c] = (n != 0);

    start          = 1'b1;
    cfg_num_groups = 10'(n);
    cfg_ifm_base   = ib;
    cfg_wgt_base   = wb;
    cfg_mul_en     = mul;
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      start = busy_start && (c == 2);
      if (start) begin
        cfg_num_groups = 10'($urandom_range(40, 1));
        cfg_ifm_base   = 10'($urandom);
        cfg_wgt_base   = 10'($urandom);
        cfg_mul_en     = ~mul;
      end
      mem_stall = stl[c];
      if (c == 1 && n != 0) exp_mul = mul;
      if (c == abort_at) begin
        reset_n = 1'b0;
        start   = 1'b0;
        exp_mul = 1'b0;
        #1;
        check_reset_zero();
        repeat (2) begin
          @(negedge clk);
          #1;
          check_reset_zero();
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_reset_zero();
        return;
      end
      #1;
      check_eq("rd_en", {ifm_rd_en, wgt_rd_en}, {e_rd[c], e_rd[c]});
      if (e_ad[c]) begin
        check_eq("ifm_addr", ifm_rd_addr, e_ai[c]);
        check_eq("wgt_addr", wgt_rd_addr, e_aw[c]);
      end
      check_eq("busy", busy, e_busy[c]);
      check_eq("done", done, (c == done_c));
      check_eq("pe_reset", pe_reset, e_rst[c]);
      check_eq("pe_finish", pe_finish, e_fin[c]);
      check_eq("lanes", lanes, e_lane[c]);
      check_eq("mul_en", mul_en, exp_mul);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      ifm_mem[a]  = $urandom;
      wgt_mem[a]  = $urandom;
      coef_mem[a] = $urandom;
    end
    for (int a = 0; a < 3; a++) begin
      ifm_mem[10'h010 + a] = 32'h0403_0201;
      wgt_mem[10'h020 + a] = 32'h0101_0101;
    end

    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_zero();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_reset_zero();
    idle(2);

    // Directed scenarios
    run_job(3, 10'h010, 10'h020, 1'b0, 0, 32'h0, 1'b0, 0);
    idle(2);
    run_job(1, 10'h100, 10'h200, 1'b1, 0, 32'h0, 1'b0, 0);
    idle(1);
    run_job(4, 10'h040, 10'h080, 1'b1, 0, 32'h4, 1'b0, 0);
    idle(1);
    run_job(0, 10'h055, 10'h066, 1'b0, 0, 32'h0, 1'b0, 0);
    idle(1);
    run_job(5, 10'h123, 10'h321, 1'b0, 0, 32'h0, 1'b1, 0);
    idle(1);
    run_job(20, 10'h300, 10'h310, 1'b1, 0, 32'h0, 1'b0, 5);
    run_job(2, 10'h050, 10'h060, 1'b0, 0, 32'h0, 1'b0, 0);
    idle(1);
    run_job(2, 10'h3FF, 10'h3FF, 1'b1, 0, 32'h0, 1'b0, 0);
    idle(1);

    // Back-to-back jobs, each started in the previous job's done cycle
    run_job(3, 10'h011, 10'h022, 1'b1, 0, 32'h0, 1'b0, 0);
    run_job(2, 10'h3FE, 10'h001, 1'b0, 20, 32'h0, 1'b0, 0);
    run_job(0, 10'h000, 10'h000, 1'b1, 0, 32'h0, 1'b0, 0);
    run_job(1, 10'h2AA, 10'h155, 1'b1, 0, 32'h0, 1'b0, 0);
    idle(2);

    // Randomized jobs with random stalls and random ignored starts
    for (int j = 0; j < 16; j++) begin
      int n;
      n = $urandom_range(40, 0);
      run_job(n, 10'($urandom), 10'($urandom), 1'($urandom), 30, 32'h0,
              1'($urandom), 0);
      idle($urandom_range(2, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quad_pe_feeder.md
# quad_pe_feeder

Operand sequencer directly upstream of the quad-lane PE accumulator. For a job of N channel groups, it reads one 32-bit IFM word, one 32-bit weight word and one 32-bit coefficient word per group from the local SRAMs. Each word is unpacked into four byte lanes and driven to the PE one group per cycle. The block marks the first group with `pe_reset` and the last group with `pe_finish`, so the PE's accumulator restarts and flags its result. On bubbles, all operands are forced to zero so the free-running PE accumulator holds its value.

## Interface
Parameters:
- `ADDR_W`, default 10: SRAM word-address width.
- `CNT_W`, default 10: group-count width.

Ports:
- `clk`  in  1: clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: job request; honoured only when `busy`=0.
- `cfg_num_groups`  in  CNT_W: number of groups N; sampled with `start`.
- `cfg_ifm_base`  in  ADDR_W: IFM start word address; sampled with `start`.
- `cfg_wgt_base`  in  ADDR_W: weight/coef start word address; sampled with `start`.
- `cfg_mul_en`  in  1: coefficient-multiply enable; sampled with `start`.
- `mem_stall`  in  1: when 1, no read is issued this cycle.
- `ifm_rd_en`  out  1: IFM SRAM read strobe.
- `ifm_rd_addr`  out  ADDR_W: IFM SRAM read address.
- `ifm_rd_data`  in  32: IFM word, valid the cycle after `ifm_rd_en`.
- `wgt_rd_en`  out  1: read strobe shared by the weight and coef SRAMs.
- `wgt_rd_addr`  out  ADDR_W: address shared by the weight and coef SRAMs.
- `wgt_rd_data`  in  32: weight word, 1-cycle read latency.
- `coef_rd_data`  in  32: coef word, 1-cycle read latency.
- `ifm1`..`ifm4`  out  8 each: IFM lanes; lane k = `ifm_rd_data[8k-1:8k-8]`.
- `weight1`..`weight4`  out  8 each: weight lanes, same byte order.
- `coef1`..`coef4`  out  8 each: coef lanes, same byte order.
- `mul_en`  out  1: latched `cfg_mul_en`, held until the next accepted start.
- `pe_reset`  out  1: high with group 0's operands.
- `pe_finish`  out  1: high with group N-1's operands.
- `busy`  out  1: job in progress.
- `done`  out  1: one-cycle pulse at job end.

## Operation
State machine, states IDLE / ISSUE / DRAIN:
- **IDLE**
  - `start` with N≠0: latch the config, clear the counter, go to ISSUE.
  - `start` with N=0: pulse `done` in the next cycle, stay in IDLE; no reads and no `pe_reset`/`pe_finish`.
- **ISSUE**, each cycle with `mem_stall`=0:
  - Assert both read strobes.
  - Drive both addresses as base + cnt; address arithmetic wraps modulo 2^ADDR_W.
  - Increment cnt.
  - After issuing cnt = N-1, go to DRAIN.
- **ISSUE**, cycle with `mem_stall`=1: strobes low; addresses and cnt held.
- **DRAIN**: wait for the last group to leave the output stage, then go to IDLE.

Two-stage valid/first/last tag pipeline:
- Stage 1 is aligned with the returned read data.
- Stage 2 is the output register.
- At the output register:
  - Valid tag: load the unpacked lanes.
  - Bubble: load zeros on every operand lane, with `pe_reset`=0 and `pe_finish`=0.
- N=1: `pe_reset` and `pe_finish` are high in the same cycle.

Other rules:
- `start` while `busy`=1 is ignored; the config is not re-sampled.
- `start` in the `done` cycle is accepted (back-to-back jobs).
- Reset, asserted at any time, aborts the job and returns the block to IDLE.

## Timing
- Reset values: every output 0, including all lanes, strobes, addresses, `mul_en`, `busy` and `done`.
- Cycle numbering, no stall, `start` sampled at edge E0:
  - Cycle 1: first read issued.
  - Cycle 2: read data on the bus.
  - Cycle 3: group 0 on the PE ports with `pe_reset`=1.
  - Cycle N+2: group N-1 on the PE ports with `pe_finish`=1.
  - Cycle N+3: `done`=1; the PE's valid and final OFM appear in this same cycle.
- `busy`=1 from cycle 1 through cycle N+2.
- Read-to-PE latency is 2 cycles.
- Each stalled cycle delays all later groups by one cycle and inserts one zero bubble into the operand stream.
- A stall never disturbs data already in flight.

## Structure
- `quad_pe_pkg` contains:
  - state enum `feeder_state_t`.
  - `LANES`=4 and `LANE_W`=8.
  - function `unpack_lane(word, k)`.
  - packed struct `pe_operands_t` carrying 4×ifm, 4×weight, 4×coef, `pe_reset` and `pe_finish`.
- Single module, no sub-module; the FSM, counter and 2-stage tag pipeline live in `quad_pe_feeder`.

## Test plan
- N=3, base 0x010/0x020, IFM words 0x04030201, weights 0x01010101, `mul_en`=0 → reads at cycles 1-3; lanes 1,2,3,4 in cycles 3-5; `pe_reset` in cycle 3; `pe_finish` in cycle 5; `done` in cycle 6.
- N=1 → `pe_reset` and `pe_finish` both high in cycle 3; `done` in cycle 4.
- N=4 with `mem_stall`=1 in cycle 2 → reads at cycles 1,3,4,5; bubble in cycle 4 with all operands 0; `pe_finish` in cycle 7; `done` in cycle 8.
- N=0 `start` → `done` in cycle 1; no read strobe; `busy` stays 0. `start` while busy → ignored.
- `reset_n` low mid-ISSUE, then `start` with N=2 → all outputs 0 during reset; new job runs from `cfg_ifm_base` cleanly.
- Base 0x3FF with N=2 → addresses 0x3FF then 0x000.
